// File: rtl/cgra_cfg_pkg.sv
// Shared CGRA tile configuration: loader state encoding and default sizes.
package cgra_cfg_pkg;

   localparam int unsigned DEFAULT_WIDTH      = 16;
   localparam int unsigned DEFAULT_NUM_INPUTS = 8;
   localparam int unsigned FRAME_CNT_W        = 16;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      WRITE   = 2'd1,
      DISCARD = 2'd2
   } loader_state_e;

endpackage

// File: rtl/regfile_loader_if.sv
// Network word stream in, register-file parallel write port out.
// master = network/register-file side, slave = the loader.
interface regfile_loader_if
   import cgra_cfg_pkg::*;
#(
   parameter int unsigned width      = DEFAULT_WIDTH,
   parameter int unsigned num_inputs = DEFAULT_NUM_INPUTS
);

   logic                             in_valid;
   logic [width-1:0]                 in_data;
   logic                             in_last;
   logic                             in_ready;
   logic                             wen;
   logic [num_inputs:0][width-1:0]   w_data;
   logic                             wr_ack;

   modport master (
      output in_valid, in_data, in_last, wr_ack,
      input  in_ready, wen, w_data
   );

   modport slave (
      input  in_valid, in_data, in_last, wr_ack,
      output in_ready, wen, w_data
   );

endinterface

// File: rtl/regfile_loader.sv
// Assembles num_inputs vector words plus one config word from the network
// into a frame buffer and holds it on the register-file write port until
// acknowledged. Optional write-ack timeout: REGFILE_LOADER_TIMEOUT_EN.
module regfile_loader
   import cgra_cfg_pkg::*;
#(
   parameter int unsigned width       = DEFAULT_WIDTH,
   parameter int unsigned num_inputs  = DEFAULT_NUM_INPUTS,
   parameter int unsigned ack_timeout = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   regfile_loader_if.slave        bus,
   output logic                   busy,
   output logic                   frame_err,
   output logic [FRAME_CNT_W-1:0] frame_cnt,
   output logic                   ack_timeout_err
);

   localparam int unsigned      IDX_W    = (num_inputs > 0) ? $clog2(num_inputs + 1) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(num_inputs);

   loader_state_e    state;
   logic [IDX_W-1:0] idx;
   logic             first_wr;
   logic [width-1:0] word_c;
   logic             accept_c;
   logic             ack_c;
   logic             timeout_c;

   assign word_c   = bus.in_data;
   assign accept_c = bus.in_valid && bus.in_ready;
   // An ack seen in the first WRITE cycle may belong to the previous frame.
   assign ack_c    = bus.wr_ack && !first_wr;

`ifdef REGFILE_LOADER_TIMEOUT_EN
   localparam int unsigned     TO_W    = (ack_timeout > 1) ? $clog2(ack_timeout) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(ack_timeout - 1);

   logic [TO_W-1:0] wr_cnt;

   // Last permitted WRITE cycle without an ack.
   assign timeout_c = (wr_cnt == TO_LAST);
`else
   // No timeout built in: WRITE waits for the ack indefinitely.
   assign timeout_c       = 1'b0;
   assign ack_timeout_err = (ack_timeout == 0) & 1'b0;
`endif

   // Frame collection, write hand-off and status, all registered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= COLLECT;
         idx          <= '0;
         first_wr     <= 1'b0;
         bus.in_ready <= 1'b1;
         bus.wen      <= 1'b0;
         bus.w_data   <= '0;
         busy         <= 1'b0;
         frame_err    <= 1'b0;
         frame_cnt    <= '0;
`ifdef REGFILE_LOADER_TIMEOUT_EN
         wr_cnt          <= '0;
         ack_timeout_err <= 1'b0;
`endif
      end else begin
         frame_err <= 1'b0;
         unique case (state)
            COLLECT: begin
               if (accept_c) begin
                  if (idx == LAST_IDX) begin
                     idx <= '0;
                     if (bus.in_last) begin
                        // Config word closes a well-formed frame.
                        bus.w_data[idx] <= word_c;
                        state           <= WRITE;
                        bus.wen         <= 1'b1;
                        bus.in_ready    <= 1'b0;
                        busy            <= 1'b1;
                        first_wr        <= 1'b1;
`ifdef REGFILE_LOADER_TIMEOUT_EN
                        wr_cnt          <= '0;
`endif
                     end else begin
                        // Frame too long: drop this word and the rest.
                        frame_err <= 1'b1;
                        state     <= DISCARD;
                     end
                  end else begin
                     bus.w_data[idx] <= word_c;
                     if (bus.in_last) begin
                        // Frame too short: partial data stays, never written.
                        idx       <= '0;
                        frame_err <= 1'b1;
                     end else begin
                        idx <= idx + IDX_W'(1);
                     end
                  end
               end
            end

            WRITE: begin
               first_wr <= 1'b0;
               if (ack_c) begin
                  state        <= COLLECT;
                  bus.wen      <= 1'b0;
                  bus.in_ready <= 1'b1;
                  busy         <= 1'b0;
                  frame_cnt    <= frame_cnt + FRAME_CNT_W'(1);
               end else if (timeout_c) begin
                  state        <= COLLECT;
                  bus.wen      <= 1'b0;
                  bus.in_ready <= 1'b1;
                  busy         <= 1'b0;
`ifdef REGFILE_LOADER_TIMEOUT_EN
                  ack_timeout_err <= 1'b1;
`endif
               end
`ifdef REGFILE_LOADER_TIMEOUT_EN
               wr_cnt <= wr_cnt + TO_W'(1);
`endif
            end

            DISCARD: begin
               if (accept_c && bus.in_last) begin
                  state <= COLLECT;
               end
            end

            default: begin
               state <= COLLECT;
               idx   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_regfile_loader.sv
// Self-checking bench for regfile_loader: directed scenarios plus random
// frames of random length against a frame-level behavioural model.
module tb_regfile_loader;
   import cgra_cfg_pkg::*;

   localparam int unsigned W           = 16;
   localparam int unsigned N           = 8;
   localparam int unsigned ACK_TO      = 8;
   localparam int          CYCLE_LIMIT = 200;
`ifdef REGFILE_LOADER_TIMEOUT_EN
   localparam int          HOLD_CYC    = 5;
`else
   localparam int          HOLD_CYC    = 20;
`endif

   logic                   clk;
   logic                   reset;
   logic                   busy;
   logic                   frame_err;
   logic                   ack_timeout_err;
   logic [FRAME_CNT_W-1:0] frame_cnt;

   regfile_loader_if #(.width(W), .num_inputs(N)) bus ();

   regfile_loader #(
      .width       (W),
      .num_inputs  (N),
      .ack_timeout (ACK_TO)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .bus             (bus),
      .busy            (busy),
      .frame_err       (frame_err),
      .frame_cnt       (frame_cnt),
      .ack_timeout_err (ack_timeout_err)
   );

   int total = 0;
   int bad   = 0;

   // Model: expected frame buffer contents and committed-frame count.
   logic [N:0][W-1:0] exp_w;
   int                exp_cnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) begin
         bus.in_data = W'($urandom);
         bus.in_last = 1'($urandom);
         @(posedge clk); #1;
      end
      bus.in_last = 1'b0;
   endtask

   task automatic send_word(input logic [W-1:0] d, input logic last,
                            output logic ferr, output logic wen_s, output logic rdy_s);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = last;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      ferr  = frame_err;
      wen_s = bus.wen;
      rdy_s = bus.in_ready;
   endtask

   // Send a len-word frame; words 1..len when seq, random otherwise.
   task automatic send_frame(input int len, input int max_gap, input logic seq, input string tag);
      logic [W-1:0] d;
      logic [3:0]   pos;
      logic         ferr, wen_s, rdy_s, exp_ferr, exp_wen;
      for (int i = 0; i < len; i++) begin
         if (max_gap > 0) idle($urandom_range(max_gap, 0));
         d   = seq ? W'(i + 1) : W'($urandom);
         pos = 4'(i);
         // Slots 0..N-1 always take the word; slot N only if it closes the frame.
         if (i < N || (i == N && len == N + 1)) exp_w[pos] = d;
         send_word(d, (i == len - 1), ferr, wen_s, rdy_s);
         exp_ferr = (len < N + 1 && i == len - 1) || (len > N + 1 && i == N);
         exp_wen  = (len == N + 1 && i == N);
         total++;
         if (ferr !== exp_ferr) begin
            bad++;
            $display("FAIL %s frame_err word %0d: got %b want %b", tag, i, ferr, exp_ferr);
         end
         total++;
         if (wen_s !== exp_wen) begin
            bad++;
            $display("FAIL %s wen word %0d: got %b want %b", tag, i, wen_s, exp_wen);
         end
         if (!exp_wen) begin
            total++;
            if (rdy_s !== 1'b1) begin
               bad++;
               $display("FAIL %s in_ready word %0d: got %b want 1", tag, i, rdy_s);
            end
         end
      end
      total++;
      if (bus.w_data !== exp_w) begin
         bad++;
         $display("FAIL %s w_data: got %h want %h", tag, bus.w_data, exp_w);
      end
   endtask

   // Register file raises wr_ack d cycles into WRITE and holds it until wen drops.
   task automatic do_write(input int d, input string tag);
      int hi = 0;
      int c  = 0;
      int exp_hi;
      exp_hi = (d + 1 < 2) ? 2 : d + 1;
      while (bus.wen === 1'b1 && c < CYCLE_LIMIT) begin
         hi++;
         total++;
         if (bus.in_ready !== 1'b0 || busy !== 1'b1 || bus.w_data !== exp_w) begin
            bad++;
            $display("FAIL %s write hold c%0d: rdy=%b busy=%b w_data=%h want rdy=0 busy=1 w_data=%h",
                     tag, c, bus.in_ready, busy, bus.w_data, exp_w);
         end
         if (c >= d) bus.wr_ack = 1'b1;
         @(posedge clk); #1;
         c++;
      end
      bus.wr_ack = 1'b0;
      exp_cnt++;
      total++;
      if (hi != exp_hi) begin
         bad++;
         $display("FAIL %s wen cycles: got %0d want %0d", tag, hi, exp_hi);
      end
      total++;
      if (frame_cnt !== FRAME_CNT_W'(exp_cnt)) begin
         bad++;
         $display("FAIL %s frame_cnt: got %0d want %0d", tag, frame_cnt, exp_cnt);
      end
      total++;
      if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL %s after write: rdy=%b busy=%b want rdy=1 busy=0", tag, bus.in_ready, busy);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      total++;
      if (bus.in_ready !== 1'b1 || bus.wen !== 1'b0 || busy !== 1'b0 ||
          frame_err !== 1'b0 || ack_timeout_err !== 1'b0) begin
         bad++;
         $display("FAIL %s flags: rdy=%b wen=%b busy=%b ferr=%b toerr=%b want 1 0 0 0 0",
                  tag, bus.in_ready, bus.wen, busy, frame_err, ack_timeout_err);
      end
      total++;
      if (bus.w_data !== '0 || frame_cnt !== '0) begin
         bad++;
         $display("FAIL %s data: w_data=%h frame_cnt=%0d want 0 0", tag, bus.w_data, frame_cnt);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #12;
      check_reset_vals("reset");
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_good_frame();
      send_frame(N + 1, 0, 1'b1, "good");
      do_write(1, "good");
   endtask

   task automatic test_short_frame();
      send_frame(4, 0, 1'b0, "short");
      send_frame(N + 1, 1, 1'b0, "short_next");
      do_write(1, "short_next");
   endtask

   task automatic test_long_frame();
      send_frame(12, 0, 1'b0, "long");
      idle(2);
      total++;
      if (bus.wen !== 1'b0 || bus.in_ready !== 1'b1 || frame_cnt !== FRAME_CNT_W'(exp_cnt)) begin
         bad++;
         $display("FAIL long after: wen=%b rdy=%b cnt=%0d want 0 1 %0d",
                  bus.wen, bus.in_ready, frame_cnt, exp_cnt);
      end
      send_frame(N + 1, 0, 1'b0, "long_next");
      do_write(0, "long_next");
   endtask

   task automatic test_ack_hold();
      send_frame(N + 1, 0, 1'b0, "hold");
      do_write(HOLD_CYC, "hold");
   endtask

   task automatic test_back_to_back();
      for (int f = 0; f < 40; f++) begin
         int len;
         len = ($urandom_range(2, 0) != 0) ? N + 1 : $urandom_range(12, 1);
         send_frame(len, (f < 10) ? 0 : 2, 1'b0, "rand");
         if (len == N + 1) do_write($urandom_range(3, 0), "rand");
      end
   endtask

`ifdef REGFILE_LOADER_TIMEOUT_EN
   task automatic test_timeout();
      int hi = 0;
      send_frame(N + 1, 0, 1'b0, "timeout");
      while (bus.wen === 1'b1 && hi < CYCLE_LIMIT) begin
         hi++;
         @(posedge clk); #1;
      end
      total++;
      if (hi != int'(ACK_TO)) begin
         bad++;
         $display("FAIL timeout wen cycles: got %0d want %0d", hi, ACK_TO);
      end
      total++;
      if (ack_timeout_err !== 1'b1 || frame_cnt !== FRAME_CNT_W'(exp_cnt) || bus.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL timeout status: err=%b cnt=%0d rdy=%b want 1 %0d 1",
                  ack_timeout_err, frame_cnt, bus.in_ready, exp_cnt);
      end
      send_frame(N + 1, 0, 1'b0, "timeout_next");
      do_write(1, "timeout_next");
      total++;
      if (ack_timeout_err !== 1'b1) begin
         bad++;
         $display("FAIL timeout sticky: got %b want 1", ack_timeout_err);
      end
   endtask
`endif

   task automatic test_async_reset();
      send_frame(N + 1, 0, 1'b0, "async");
      #2;
      reset = 1'b0;
      #1;
      exp_cnt = 0;
      exp_w   = '0;
      check_reset_vals("async_reset");
      #2;
      reset = 1'b1;
      @(posedge clk); #1;
      send_frame(N + 1, 0, 1'b0, "after_reset");
      do_write(1, "after_reset");
   endtask

   initial begin
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_last  = 1'b0;
      bus.wr_ack   = 1'b0;
      exp_w        = '0;
      exp_cnt      = 0;

      test_reset();
      test_good_frame();
      test_short_frame();
      test_long_frame();
      test_ack_hold();
      test_back_to_back();
`ifdef REGFILE_LOADER_TIMEOUT_EN
      test_timeout();
`endif
      test_async_reset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
